// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package regfile_pkg;
    localparam int DATAW = 32;
    localparam int ADDRW = 5;
    localparam int NREG  = 32;
    localparam logic [ADDRW-1:0] ZERO_REG = '0;

    typedef enum logic {SRC_ALU = 1'b0, SRC_LOAD = 1'b1} src_e;

    function automatic logic [NREG-1:0] onehot(input logic [ADDRW-1:0] a);
        return {{(NREG-1){1'b0}}, 1'b1} << a;
    endfunction
endpackage

// File: rtl/regfile_wb_sched_if.sv
// Write-back sources, issue/query ports and register-file write port of the scheduler.
interface regfile_wb_sched_if;
    import regfile_pkg::*;
    logic             s0_valid, s0_ready;
    logic [ADDRW-1:0] s0_addr;
    logic [DATAW-1:0] s0_data;
    logic             s1_valid, s1_ready;
    logic [ADDRW-1:0] s1_addr;
    logic [DATAW-1:0] s1_data;
    logic             iss_valid;
    logic [ADDRW-1:0] iss_addr;
    logic [ADDRW-1:0] q1_addr, q2_addr;
    logic             q1_busy, q2_busy;
    logic             rf_wrenable;
    logic [ADDRW-1:0] rf_a3;
    logic [DATAW-1:0] rf_wr;

    modport master (
        output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
               iss_valid, iss_addr, q1_addr, q2_addr,
        input  s0_ready, s1_ready, q1_busy, q2_busy, rf_wrenable, rf_a3, rf_wr
    );
    modport slave (
        input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
               iss_valid, iss_addr, q1_addr, q2_addr,
        output s0_ready, s1_ready, q1_busy, q2_busy, rf_wrenable, rf_a3, rf_wr
    );
endinterface

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter; last grant advances only when a grant is taken.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_ack,
    output logic [1:0] o_gnt
);
    src_e r_last;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11)
            o_gnt = (r_last == SRC_LOAD) ? 2'b01 : 2'b10;
    end

    // Reset to SRC_LOAD so the ALU source wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            r_last <= SRC_LOAD;
        else if (i_ack)
            r_last <= o_gnt[1] ? SRC_LOAD : SRC_ALU;
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU/load results onto the single register-file
// write port and keeps the per-register pending-write scoreboard.
module regfile_wb_sched
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    regfile_wb_sched_if.slave  bus
);
    logic [1:0]       w_req, w_gnt;
    logic             w_xfer;
    logic [ADDRW-1:0] w_addr;
    logic [DATAW-1:0] w_data;
    logic [NREG-1:0]  w_set, w_clr;
    logic [NREG-1:0]  r_busy;
    logic             r_we;
    logic [ADDRW-1:0] r_a3;
    logic [DATAW-1:0] r_wr;

    // No handshake during reset, so no write-back is accepted and then dropped.
    assign w_req = {bus.s1_valid, bus.s0_valid} & {2{~reset}};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .i_req (w_req),
        .i_ack (w_xfer),
        .o_gnt (w_gnt)
    );

    assign bus.s0_ready = w_gnt[0];
    assign bus.s1_ready = w_gnt[1];
    assign w_xfer       = |w_gnt;
    assign w_addr       = w_gnt[1] ? bus.s1_addr : bus.s0_addr;
    assign w_data       = w_gnt[1] ? bus.s1_data : bus.s0_data;

    // Set is applied after clear so a new producer keeps the register busy.
    assign w_clr = w_xfer ? onehot(w_addr) : '0;
    assign w_set = (bus.iss_valid && bus.iss_addr != ZERO_REG) ? onehot(bus.iss_addr) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_we   <= 1'b0;
            r_a3   <= '0;
            r_wr   <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
            r_we   <= w_xfer && (w_addr != ZERO_REG);
            if (w_xfer && w_addr != ZERO_REG) begin
                r_a3 <= w_addr;
                r_wr <= w_data;
            end
        end
    end

    assign bus.rf_wrenable = r_we;
    assign bus.rf_a3       = r_a3;
    assign bus.rf_wr       = r_wr;
    assign bus.q1_busy     = r_busy[bus.q1_addr];
    assign bus.q2_busy     = r_busy[bus.q2_addr];
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: per-cycle model comparison plus literal checks.
module tb_regfile_wb_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_sched_if bus();

    regfile_wb_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    // Model state: pending bits, last winner (0=ALU, 1=load), visible write port.
    bit        m_busy [32];
    int        m_last;
    bit        m_we;
    bit [4:0]  m_a3;
    bit [31:0] m_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_grant();
        if (reset) return -1;
        if (bus.s0_valid && bus.s1_valid) return (m_last == 1) ? 0 : 1;
        if (bus.s0_valid) return 0;
        if (bus.s1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        bit [4:0]  a;
        bit [31:0] d;
        g = exp_grant();
        if (reset) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_last = 1; m_we = 1'b0; m_a3 = '0; m_wr = '0;
        end else begin
            m_we = 1'b0;
            if (g >= 0) begin
                a = (g == 1) ? bus.s1_addr : bus.s0_addr;
                d = (g == 1) ? bus.s1_data : bus.s0_data;
                m_last = g;
                m_busy[a] = 1'b0;
                if (a != 0) begin m_we = 1'b1; m_a3 = a; m_wr = d; end
            end
            if (bus.iss_valid && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        int g;
        if (chk_en) begin
            g = exp_grant();
            chk("m_s0_ready", bus.s0_ready, g == 0);
            chk("m_s1_ready", bus.s1_ready, g == 1);
            chk("m_q1_busy", bus.q1_busy, m_busy[bus.q1_addr]);
            chk("m_q2_busy", bus.q2_busy, m_busy[bus.q2_addr]);
            chk("m_rf_wrenable", bus.rf_wrenable, m_we);
            chk("m_rf_a3", bus.rf_a3, m_a3);
            chk("m_rf_wr", bus.rf_wr, m_wr);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    initial begin
        bus.s0_valid = 0; bus.s0_addr = 0; bus.s0_data = 0;
        bus.s1_valid = 0; bus.s1_addr = 0; bus.s1_data = 0;
        bus.iss_valid = 0; bus.iss_addr = 0; bus.q1_addr = 0; bus.q2_addr = 0;
        tick(); chk_en = 1'b1; tick();
        reset = 1'b0;
        at_neg();
        chk("rst_wrenable", bus.rf_wrenable, 0);
        chk("rst_a3", bus.rf_a3, 0);
        chk("rst_wr", bus.rf_wr, 0);
        chk("rst_q1", bus.q1_busy, 0);

        // 1: single ALU write
        tick();
        bus.s0_valid = 1; bus.s0_addr = 5; bus.s0_data = 32'hDEADBEEF;
        at_neg(); chk("t1_s0_ready", bus.s0_ready, 1);
        tick(); bus.s0_valid = 0;
        at_neg();
        chk("t1_we", bus.rf_wrenable, 1);
        chk("t1_a3", bus.rf_a3, 5);
        chk("t1_wr", bus.rf_wr, 32'hDEADBEEF);

        // Lone load write so the next tie goes to the ALU.
        tick(); bus.s1_valid = 1; bus.s1_addr = 6; bus.s1_data = 32'h66;
        tick(); bus.s1_valid = 0;

        // 2: both valid for three cycles -> s0, s1, s0
        bus.s0_valid = 1; bus.s0_addr = 3; bus.s0_data = 32'hA3;
        bus.s1_valid = 1; bus.s1_addr = 4; bus.s1_data = 32'hC4;
        at_neg();
        chk("t2c1_s0", bus.s0_ready, 1); chk("t2c1_s1", bus.s1_ready, 0);
        chk("t2c1_a3", bus.rf_a3, 6);
        tick(); bus.s0_data = 32'hB3;
        at_neg();
        chk("t2c2_s0", bus.s0_ready, 0); chk("t2c2_s1", bus.s1_ready, 1);
        chk("t2c2_wr", bus.rf_wr, 32'hA3);
        tick();
        at_neg();
        chk("t2c3_s0", bus.s0_ready, 1); chk("t2c3_s1", bus.s1_ready, 0);
        chk("t2c3_a3", bus.rf_a3, 4); chk("t2c3_wr", bus.rf_wr, 32'hC4);
        tick(); bus.s0_valid = 0; bus.s1_valid = 0;
        at_neg(); chk("t2c4_wr", bus.rf_wr, 32'hB3);

        // 3: issue to r7, then load write-back clears it
        tick(); bus.iss_valid = 1; bus.iss_addr = 7; bus.q1_addr = 7;
        tick(); bus.iss_valid = 0;
        at_neg(); chk("t3_busy_set", bus.q1_busy, 1);
        tick(); bus.s1_valid = 1; bus.s1_addr = 7; bus.s1_data = 32'h77;
        at_neg(); chk("t3_s1_ready", bus.s1_ready, 1); chk("t3_no_bypass", bus.q1_busy, 1);
        tick(); bus.s1_valid = 0;
        at_neg(); chk("t3_busy_clr", bus.q1_busy, 0); chk("t3_a3", bus.rf_a3, 7);

        // 4: register 0 write and issue
        tick();
        bus.s0_valid = 1; bus.s0_addr = 0; bus.s0_data = 32'h1234;
        bus.iss_valid = 1; bus.iss_addr = 0; bus.q1_addr = 0;
        at_neg(); chk("t4_s0_ready", bus.s0_ready, 1);
        tick(); bus.s0_valid = 0; bus.iss_valid = 0;
        at_neg(); chk("t4_we", bus.rf_wrenable, 0); chk("t4_q1_r0", bus.q1_busy, 0);

        // 5: set and clear of r9 in the same cycle
        tick();
        bus.s0_valid = 1; bus.s0_addr = 9; bus.s0_data = 32'h99;
        bus.iss_valid = 1; bus.iss_addr = 9; bus.q2_addr = 9;
        tick(); bus.s0_valid = 0; bus.iss_valid = 0;
        at_neg(); chk("t5_busy9", bus.q2_busy, 1); chk("t5_we", bus.rf_wrenable, 1);

        // 6: reset during back-to-back writes
        tick();
        bus.s0_valid = 1; bus.s0_addr = 10; bus.s0_data = 32'hAA;
        bus.s1_valid = 1; bus.s1_addr = 11; bus.s1_data = 32'hBB;
        bus.iss_valid = 1; bus.iss_addr = 12; bus.q1_addr = 12;
        tick(); bus.iss_valid = 0; reset = 1'b1;
        at_neg(); chk("t6_inflight_we", bus.rf_wrenable, 1);
        tick(); reset = 1'b0;
        at_neg();
        chk("t6_we", bus.rf_wrenable, 0);
        chk("t6_q1", bus.q1_busy, 0);
        chk("t6_q2", bus.q2_busy, 0);
        chk("t6_tie_s0", bus.s0_ready, 1);
        chk("t6_tie_s1", bus.s1_ready, 0);
        tick(); bus.s0_valid = 0;
        tick(); bus.s1_valid = 0;
        at_neg(); chk("t6_a3", bus.rf_a3, 11);
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
